arilla_bus_arbiter: RTL and testbench
=====================================

ARILLA_BUS_ARBITER -- requirements
Module: arilla_bus_arbiter

Interface
REQ-001 SHALL have parameters: DataWidth, default 32, data width; AddressWidth, default 32, byte address width; ByteSize, default 8, bits per byte-enable lane; TimeoutCycles, default 255, maximum BUSY cycles before abort.
REQ-002 SHALL have one clock and a synchronous active-high reset; the ports are listed below, and the m<N>_ ports exist for N=0 (core) and N=1 (debug system-bus access).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 inhibit  in  1  high: no new grants are issued.
REQ-006 m<N>_req  in  1  master N requests a transaction; held until m<N>_done.
REQ-007 m<N>_we  in  1  1 = write, 0 = read.
REQ-008 m<N>_addr  in  AddressWidth  byte address.
REQ-009 m<N>_wdata  in  DataWidth  write data.
REQ-010 m<N>_be  in  DataWidth/ByteSize  byte enables.
REQ-011 m<N>_done  out  1  one-cycle completion pulse to master N.
REQ-012 m<N>_err  out  1  error flag, valid only with m<N>_done.
REQ-013 m<N>_rdata  out  DataWidth  read data, valid only with m<N>_done.
REQ-014 s_req, s_we, s_addr, s_wdata, s_be  out  1/1/AddressWidth/DataWidth/DataWidth/ByteSize  command to the shared slave bus.
REQ-015 s_done, s_err, s_rdata  in  1/1/DataWidth  slave completion, error flag and read data.
REQ-016 owner  out  2  one-hot current owner (bit N = master N); 00 when idle.

Function
REQ-017 SHALL implement states IDLE, BUSY and RESP, plus an owner register and a last_grant register.
REQ-018 In IDLE with inhibit=0:
- single requester: SHALL be granted;
- both requesting: SHALL grant the master not equal to last_grant (round-robin);
- no requester: SHALL stay in IDLE.
REQ-019 In IDLE with inhibit=1: SHALL stay in IDLE; inhibit SHALL be ignored in BUSY and RESP.
REQ-020 On grant SHALL:
- capture the winner's we/addr/wdata/be into s_* registers;
- set owner and last_grant;
- clear the timeout counter;
- enter BUSY.
With m<N>_req seen at cycle t, s_req SHALL be high from t+1.
REQ-021 In BUSY, s_req SHALL be high and s_* fields stable; master input changes SHALL be ignored.
REQ-022 In BUSY, s_done=1 SHALL:
- latch s_rdata and s_err;
- drop s_req next cycle;
- enter RESP.
REQ-023 In BUSY without s_done, the counter SHALL increment each cycle. When it equals TimeoutCycles, the block SHALL enter RESP with err=1 and rdata=0.
REQ-024 If s_done and the timeout occur in the same cycle, s_done SHALL win.
REQ-025 In RESP, m<owner>_done SHALL be 1 for exactly one cycle, with latched rdata and err.
REQ-026 The non-owner's done SHALL be 0; its rdata and err SHALL be 0.
REQ-027 RESP SHALL always go to IDLE; no arbitration occurs in RESP.
REQ-028 Masters SHALL deassert req, or present a new command, by the cycle after done.
REQ-029 Timing SHALL be: minimum transaction req -> done 2 cycles; back-to-back grants at most once per 3 cycles.
REQ-030 s_done received outside BUSY SHALL be ignored.

Reset
REQ-031 On rst, the next state SHALL be IDLE, and the counter SHALL be 0.
REQ-032 On rst, outputs SHALL reset to: s_req=0, s_* fields=0, m<N>_done=0, m<N>_err=0, m<N>_rdata=0, owner=00.
REQ-033 On rst, last_grant SHALL reset to 1, so master 0 wins the first tie.
REQ-034 Reset during BUSY or RESP SHALL abort the transaction without issuing done; a late s_done SHALL be discarded.

Structure
REQ-035 A shared package arilla_arb_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and the master index constants (CORE=0, DEBUG=1).
REQ-036 The timeout counter SHALL be the sub-module arilla_timeout_counter, with clear, enable and expired signals and a TimeoutCycles parameter.

Verification
REQ-037 m0 reads addr 0x100; s_done is asserted 3 cycles after s_req with s_rdata=0xDEADBEEF -> m0_done is one pulse 1 cycle later, rdata=0xDEADBEEF, err=0, and m1_done stays 0.
REQ-038 m0 and m1 request in the same cycle after reset -> m0 is served first, then m1. With both held for 4 transactions, the grant order is 0,1,0,1.
REQ-039 A slave that never asserts s_done, TimeoutCycles=8 -> s_req is high for exactly 8 cycles, then the owner gets done=1, err=1, rdata=0.
REQ-040 inhibit=1 while m1 requests for 10 cycles -> s_req stays 0. Raise inhibit during BUSY -> the transaction still completes.
REQ-041 rst asserted mid-BUSY, with s_done arriving 1 cycle after rst -> no m<N>_done; all outputs reset; the next request is granted normally.
REQ-042 m1 writes wdata=0x12345678, be=0b0011, and changes addr while BUSY -> s_addr, s_wdata and s_be hold the captured values until s_done.

Source files
------------

// File: rtl/arilla_bus_arbiter_pkg.sv
// Shared types and constants for the two-master arilla bus arbiter.
// Master 0 is the core and master 1 is debug system-bus access.
package arilla_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int CORE  = 0;
  localparam int DEBUG = 1;

  // Round-robin pick: on a tie the master that did not win last time is chosen.
  function automatic logic pickWinner(input logic req0, input logic req1, input logic lastGrant);
    if (req0 && req1) begin
      return ~lastGrant;
    end
    return req1;
  endfunction

endpackage

// File: rtl/arilla_bus_arbiter_if.sv
// Simple request/done bus. The arbiter takes the slave modport from each master
// and drives the shared slave bus through the master modport.
interface arilla_bus_arbiter_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int ByteSize     = 8
);
  localparam int BeWidth = DataWidth / ByteSize;

  logic                    req;
  logic                    we;
  logic [AddressWidth-1:0] addr;
  logic [DataWidth-1:0]    wdata;
  logic [BeWidth-1:0]      be;
  logic                    done;
  logic                    err;
  logic [DataWidth-1:0]    rdata;

  modport master (output req, we, addr, wdata, be, input done, err, rdata);
  modport slave  (input req, we, addr, wdata, be, output done, err, rdata);

endinterface

// File: rtl/arilla_timeout_counter.sv
// Counts BUSY cycles without a slave response; expired_o fires on the cycle
// whose increment would make the count reach TimeoutCycles.
module arilla_timeout_counter #(
  parameter int TimeoutCycles = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] count_q;
  logic [CntWidth-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == CntWidth'(TimeoutCycles - 1));

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between the core (m0) and debug (m1).
// One transaction at a time: IDLE grants, BUSY waits for the slave, RESP pulses done.
module arilla_bus_arbiter
  import arilla_arb_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int ByteSize      = 8,
  parameter int TimeoutCycles = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inhibit,
  arilla_bus_arbiter_if.slave   m0,
  arilla_bus_arbiter_if.slave   m1,
  arilla_bus_arbiter_if.master  s,
  output logic [1:0]            owner
);
  localparam int BeWidth = DataWidth / ByteSize;

  arb_state_e              state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic                    lastGrant_q, lastGrant_d;
  logic                    cmdWe_q, cmdWe_d;
  logic [AddressWidth-1:0] cmdAddr_q, cmdAddr_d;
  logic [DataWidth-1:0]    cmdWdata_q, cmdWdata_d;
  logic [BeWidth-1:0]      cmdBe_q, cmdBe_d;
  logic [DataWidth-1:0]    rspRdata_q, rspRdata_d;
  logic                    rspErr_q, rspErr_d;
  logic                    winner;
  logic                    cntClear;
  logic                    cntEnable;
  logic                    cntExpired;

  arilla_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) uTimeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cntClear),
    .enable_i (cntEnable),
    .expired_o(cntExpired)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    cmdWe_d     = cmdWe_q;
    cmdAddr_d   = cmdAddr_q;
    cmdWdata_d  = cmdWdata_q;
    cmdBe_d     = cmdBe_q;
    rspRdata_d  = rspRdata_q;
    rspErr_d    = rspErr_q;
    cntClear    = 1'b0;
    cntEnable   = 1'b0;
    winner      = pickWinner(m0.req, m1.req, lastGrant_q);

    unique case (state_q)
      IDLE: begin
        if (!inhibit && (m0.req || m1.req)) begin
          state_d     = BUSY;
          owner_d     = winner ? 2'b10 : 2'b01;
          lastGrant_d = winner;
          cmdWe_d     = winner ? m1.we    : m0.we;
          cmdAddr_d   = winner ? m1.addr  : m0.addr;
          cmdWdata_d  = winner ? m1.wdata : m0.wdata;
          cmdBe_d     = winner ? m1.be    : m0.be;
          cntClear    = 1'b1;
        end
      end
      BUSY: begin
        // A slave response on the timeout cycle still wins over the abort.
        if (s.done) begin
          state_d    = RESP;
          rspRdata_d = s.rdata;
          rspErr_d   = s.err;
        end else begin
          cntEnable = 1'b1;
          if (cntExpired) begin
            state_d    = RESP;
            rspRdata_d = '0;
            rspErr_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 2'b00;
      lastGrant_q <= 1'b1;
      cmdWe_q     <= 1'b0;
      cmdAddr_q   <= '0;
      cmdWdata_q  <= '0;
      cmdBe_q     <= '0;
      rspRdata_q  <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      cmdWe_q     <= cmdWe_d;
      cmdAddr_q   <= cmdAddr_d;
      cmdWdata_q  <= cmdWdata_d;
      cmdBe_q     <= cmdBe_d;
      rspRdata_q  <= rspRdata_d;
      rspErr_q    <= rspErr_d;
    end
  end

  assign s.req   = (state_q == BUSY);
  assign s.we    = cmdWe_q;
  assign s.addr  = cmdAddr_q;
  assign s.wdata = cmdWdata_q;
  assign s.be    = cmdBe_q;

  // Only the owner sees done, and response fields are zero everywhere else.
  assign m0.done  = (state_q == RESP) && owner_q[CORE];
  assign m0.err   = m0.done && rspErr_q;
  assign m0.rdata = m0.done ? rspRdata_q : '0;
  assign m1.done  = (state_q == RESP) && owner_q[DEBUG];
  assign m1.err   = m1.done && rspErr_q;
  assign m1.rdata = m1.done ? rspRdata_q : '0;

  assign owner = owner_q;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed self-checking bench for arilla_bus_arbiter with a short timeout.
module tb_arilla_bus_arbiter;

  logic       clk;
  logic       rst;
  logic       inhibit;
  logic [1:0] owner;
  int         assertCount;
  int         failCount;

  arilla_bus_arbiter_if #(.DataWidth(32), .AddressWidth(32), .ByteSize(8)) m0If ();
  arilla_bus_arbiter_if #(.DataWidth(32), .AddressWidth(32), .ByteSize(8)) m1If ();
  arilla_bus_arbiter_if #(.DataWidth(32), .AddressWidth(32), .ByteSize(8)) sIf ();

  arilla_bus_arbiter #(
    .DataWidth    (32),
    .AddressWidth (32),
    .ByteSize     (8),
    .TimeoutCycles(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .inhibit(inhibit),
    .m0     (m0If),
    .m1     (m1If),
    .s      (sIf),
    .owner  (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and report mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a command on one master and raise its request.
  task automatic applyStimulus(input int master, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    if (master == 0) begin
      m0If.req = 1'b1; m0If.we = we; m0If.addr = addr; m0If.wdata = wdata; m0If.be = be;
    end else begin
      m1If.req = 1'b1; m1If.we = we; m1If.addr = addr; m1If.wdata = wdata; m1If.be = be;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sReqCycles;
    int hiCycles;
    logic sawDone;
    logic [1:0] expOwner;

    assertCount = 0;
    failCount   = 0;
    rst = 1'b1; inhibit = 1'b0;
    m0If.req = 0; m0If.we = 0; m0If.addr = 0; m0If.wdata = 0; m0If.be = 0;
    m1If.req = 0; m1If.we = 0; m1If.addr = 0; m1If.wdata = 0; m1If.be = 0;
    sIf.done = 0; sIf.err = 0; sIf.rdata = 0;

    tick();
    tick();
    checkOutput("reset_s_req", 32'(sIf.req), 0);
    checkOutput("reset_owner", 32'(owner), 0);
    checkOutput("reset_s_addr", sIf.addr, 0);
    checkOutput("reset_m0_done", 32'(m0If.done), 0);
    checkOutput("reset_m1_rdata", m1If.rdata, 0);
    rst = 1'b0;

    // Basic read by the core with a 3-cycle slave latency.
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'hF);
    tick();
    checkOutput("rd_s_req", 32'(sIf.req), 1);
    checkOutput("rd_owner", 32'(owner), 32'h1);
    checkOutput("rd_s_addr", sIf.addr, 32'h100);
    checkOutput("rd_s_we", 32'(sIf.we), 0);
    tick();
    tick();
    tick();
    checkOutput("rd_s_req_held", 32'(sIf.req), 1);
    checkOutput("rd_no_early_done", 32'(m0If.done), 0);
    sIf.done = 1'b1; sIf.rdata = 32'hDEADBEEF;
    tick();
    sIf.done = 1'b0; sIf.rdata = 32'h0;
    checkOutput("rd_m0_done", 32'(m0If.done), 1);
    checkOutput("rd_m0_rdata", m0If.rdata, 32'hDEADBEEF);
    checkOutput("rd_m0_err", 32'(m0If.err), 0);
    checkOutput("rd_m1_done", 32'(m1If.done), 0);
    checkOutput("rd_s_req_drop", 32'(sIf.req), 0);
    m0If.req = 1'b0;
    tick();
    checkOutput("rd_done_one_pulse", 32'(m0If.done), 0);
    checkOutput("rd_owner_idle", 32'(owner), 0);

    // Fresh reset, then both masters contend for four transactions.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b0, 32'h200, 32'h0, 4'hF);
    applyStimulus(1, 1'b0, 32'h300, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      expOwner = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      checkOutput($sformatf("rr_owner_%0d", i), 32'(owner), 32'(expOwner));
      checkOutput($sformatf("rr_addr_%0d", i), sIf.addr, (i % 2 == 0) ? 32'h200 : 32'h300);
      sIf.done = 1'b1; sIf.rdata = 32'hA000 + i;
      tick();
      sIf.done = 1'b0;
      checkOutput($sformatf("rr_m0_done_%0d", i), 32'(m0If.done), 32'(expOwner[0]));
      checkOutput($sformatf("rr_m1_done_%0d", i), 32'(m1If.done), 32'(expOwner[1]));
      checkOutput($sformatf("rr_rdata_%0d", i), expOwner[0] ? m0If.rdata : m1If.rdata, 32'hA000 + i);
      tick();
    end
    m0If.req = 1'b0; m1If.req = 1'b0;
    tick();

    // Silent slave: abort after eight BUSY cycles.
    applyStimulus(0, 1'b0, 32'h500, 32'h0, 4'hF);
    tick();
    sReqCycles = 0;
    sawDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sIf.req) sReqCycles++;
      if (m0If.done) begin
        sawDone = 1'b1;
        checkOutput("to_err", 32'(m0If.err), 1);
        checkOutput("to_rdata", m0If.rdata, 0);
        break;
      end
      tick();
    end
    checkOutput("to_done_seen", 32'(sawDone), 1);
    checkOutput("to_s_req_cycles", sReqCycles, 8);
    m0If.req = 1'b0;
    tick();

    // Inhibit blocks grants in IDLE but not an ongoing transaction.
    inhibit = 1'b1;
    applyStimulus(1, 1'b0, 32'h600, 32'h0, 4'hF);
    hiCycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sIf.req) hiCycles++;
    end
    checkOutput("inh_no_grant", hiCycles, 0);
    inhibit = 1'b0;
    tick();
    checkOutput("inh_owner", 32'(owner), 32'h2);
    inhibit = 1'b1;
    sIf.done = 1'b1; sIf.rdata = 32'hCAFE0001;
    tick();
    sIf.done = 1'b0;
    checkOutput("inh_m1_done", 32'(m1If.done), 1);
    checkOutput("inh_m1_rdata", m1If.rdata, 32'hCAFE0001);
    checkOutput("inh_m0_rdata", m0If.rdata, 0);
    m1If.req = 1'b0;
    tick();
    inhibit = 1'b0;

    // Debug write: captured command must hold while the master changes inputs.
    applyStimulus(1, 1'b1, 32'h400, 32'h12345678, 4'b0011);
    tick();
    m1If.addr = 32'h999; m1If.wdata = 32'h0; m1If.be = 4'hF; m1If.we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("wr_s_addr_%0d", i), sIf.addr, 32'h400);
      checkOutput($sformatf("wr_s_wdata_%0d", i), sIf.wdata, 32'h12345678);
      checkOutput($sformatf("wr_s_be_%0d", i), 32'(sIf.be), 32'h3);
      checkOutput($sformatf("wr_s_we_%0d", i), 32'(sIf.we), 1);
      tick();
    end
    sIf.done = 1'b1; sIf.err = 1'b1;
    tick();
    sIf.done = 1'b0; sIf.err = 1'b0;
    checkOutput("wr_m1_done", 32'(m1If.done), 1);
    checkOutput("wr_m1_err", 32'(m1If.err), 1);
    checkOutput("wr_m0_err", 32'(m0If.err), 0);
    m1If.req = 1'b0;
    tick();

    // Reset in the middle of BUSY, followed by a stray slave response.
    applyStimulus(0, 1'b0, 32'h700, 32'h0, 4'hF);
    tick();
    tick();
    rst = 1'b1; m0If.req = 1'b0;
    tick();
    rst = 1'b0;
    sIf.done = 1'b1; sIf.rdata = 32'h77777777;
    checkOutput("rst_s_req", 32'(sIf.req), 0);
    checkOutput("rst_owner", 32'(owner), 0);
    checkOutput("rst_s_addr", sIf.addr, 0);
    checkOutput("rst_m0_done", 32'(m0If.done), 0);
    tick();
    sIf.done = 1'b0; sIf.rdata = 32'h0;
    checkOutput("rst_late_done_m0", 32'(m0If.done), 0);
    checkOutput("rst_late_done_m1", 32'(m1If.done), 0);
    checkOutput("rst_late_s_req", 32'(sIf.req), 0);
    applyStimulus(1, 1'b0, 32'h800, 32'h0, 4'hF);
    tick();
    checkOutput("rst_regrant_owner", 32'(owner), 32'h2);
    checkOutput("rst_regrant_addr", sIf.addr, 32'h800);
    sIf.done = 1'b1; sIf.rdata = 32'h55AA55AA;
    tick();
    sIf.done = 1'b0;
    checkOutput("rst_regrant_done", 32'(m1If.done), 1);
    checkOutput("rst_regrant_rdata", m1If.rdata, 32'h55AA55AA);
    m1If.req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
